// File: rtl/branch_sched_pkg.sv
// Shared definitions for the branch sequencing controller: branch funct3
// encodings and the controller state type.
package branch_sched_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Only the signed relational branches need the comparator in signed mode.
    function automatic logic is_signed_cmp(input logic [2:0] funct3);
        return (funct3 == BLT) || (funct3 == BGE);
    endfunction

endpackage

// File: rtl/branch_sched_br_decide.sv
// Combinational branch resolution: maps funct3 and the comparator flags to
// the taken decision and the illegal-encoding flag.
module branch_sched_br_decide
    import branch_sched_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       less,
    input  logic       equal,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            BEQ:         taken = equal;
            BNE:         taken = !equal;
            BLT, BLTU:   taken = less;
            BGE, BGEU:   taken = !less;
            default:     illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_sched.sv
// Sequencer for the shared branch comparator: accept, compare, respond, with
// a flush pulse on taken handshakes and saturating branch statistics.
module branch_sched
    import branch_sched_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int XLEN  = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_br_valid,
    output logic             o_br_ready,
    input  logic [2:0]       i_br_funct3,
    input  logic [XLEN-1:0]  i_br_pc,
    input  logic [XLEN-1:0]  i_br_imm,
    input  logic [XLEN-1:0]  i_rs1_data,
    input  logic [XLEN-1:0]  i_rs2_data,
    output logic [XLEN-1:0]  o_cmp_rs1,
    output logic [XLEN-1:0]  o_cmp_rs2,
    output logic             o_br_un,
    input  logic             i_br_less,
    input  logic             i_br_equal,
    output logic             o_resp_valid,
    input  logic             i_resp_ready,
    output logic             o_taken,
    output logic [XLEN-1:0]  o_target,
    output logic             o_illegal,
    output logic             o_misalign,
    output logic             o_flush,
    input  logic             i_kill,
    input  logic             i_cnt_clr,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_taken_cnt
);

    state_t            state_reg, state_next;
    logic [2:0]        funct3_reg;
    logic [XLEN-1:0]   pc_reg, imm_reg, rs1_reg, rs2_reg;
    logic              taken_reg, illegal_reg, misalign_reg;
    logic [XLEN-1:0]   target_reg;
    logic [CNT_W-1:0]  br_cnt_reg, taken_cnt_reg;

    logic              accept, resp_fire, count_en;
    logic              dec_taken, dec_illegal;
    logic [XLEN-1:0]   target_calc;

    branch_sched_br_decide u_br_decide (
        .funct3  (funct3_reg),
        .less    (i_br_less),
        .equal   (i_br_equal),
        .taken   (dec_taken),
        .illegal (dec_illegal)
    );

    assign target_calc = pc_reg + imm_reg;

    always_comb begin
        state_next   = state_reg;
        o_br_ready   = 1'b0;
        o_resp_valid = 1'b0;
        o_br_un      = 1'b0;
        accept       = 1'b0;
        case (state_reg)
            IDLE: begin
                o_br_ready = !i_kill;
                accept     = i_br_valid && !i_kill;
                if (accept) state_next = CMP;
            end
            CMP: begin
                o_br_un    = is_signed_cmp(funct3_reg);
                state_next = RESP;
            end
            RESP: begin
                o_resp_valid = 1'b1;
                if (i_resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Kill overrides every transition, including a completing handshake.
        if (i_kill) state_next = IDLE;
    end

    assign resp_fire = (state_reg == RESP) && i_resp_ready && !i_kill;
    assign count_en  = resp_fire && !illegal_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= IDLE;
            funct3_reg    <= '0;
            pc_reg        <= '0;
            imm_reg       <= '0;
            rs1_reg       <= '0;
            rs2_reg       <= '0;
            taken_reg     <= 1'b0;
            illegal_reg   <= 1'b0;
            misalign_reg  <= 1'b0;
            target_reg    <= '0;
            br_cnt_reg    <= '0;
            taken_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                funct3_reg <= i_br_funct3;
                pc_reg     <= i_br_pc;
                imm_reg    <= i_br_imm;
                rs1_reg    <= i_rs1_data;
                rs2_reg    <= i_rs2_data;
            end
            if (state_reg == CMP) begin
                taken_reg    <= dec_taken;
                illegal_reg  <= dec_illegal;
                target_reg   <= target_calc;
                misalign_reg <= dec_taken && (target_calc[1:0] != 2'b00);
            end
            if (i_cnt_clr) begin
                br_cnt_reg    <= '0;
                taken_cnt_reg <= '0;
            end else if (count_en) begin
                if (br_cnt_reg != '1)
                    br_cnt_reg <= br_cnt_reg + CNT_W'(1);
                if (taken_reg && (taken_cnt_reg != '1))
                    taken_cnt_reg <= taken_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign o_cmp_rs1   = rs1_reg;
    assign o_cmp_rs2   = rs2_reg;
    assign o_taken     = taken_reg;
    assign o_target    = target_reg;
    assign o_illegal   = illegal_reg;
    assign o_misalign  = misalign_reg;
    assign o_flush     = resp_fire && taken_reg;
    assign o_br_cnt    = br_cnt_reg;
    assign o_taken_cnt = taken_cnt_reg;

endmodule

// File: tb/tb_branch_sched.sv
// Randomized and directed bench for branch_sched against a behavioural model
// of branch resolution, response timing and saturating statistics.
module tb_branch_sched;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             br_valid, br_ready;
    logic [2:0]       br_funct3;
    logic [31:0]      br_pc, br_imm, rs1_data, rs2_data;
    logic [31:0]      cmp_rs1, cmp_rs2;
    logic             br_un, br_less, br_equal;
    logic             resp_valid, resp_ready;
    logic             taken, illegal, misalign, flush;
    logic [31:0]      target;
    logic             kill, cnt_clr;
    logic [CNT_W-1:0] br_cnt, taken_cnt;

    int total = 0;
    int bad   = 0;
    int m_br  = 0;
    int m_tk  = 0;

    always #5 clk = ~clk;

    // External comparator: br_un = 1 selects a signed compare.
    always_comb begin
        br_less  = br_un ? ($signed(cmp_rs1) < $signed(cmp_rs2)) : (cmp_rs1 < cmp_rs2);
        br_equal = (cmp_rs1 == cmp_rs2);
    end

    branch_sched #(.CNT_W(CNT_W), .XLEN(32)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_br_valid   (br_valid),
        .o_br_ready   (br_ready),
        .i_br_funct3  (br_funct3),
        .i_br_pc      (br_pc),
        .i_br_imm     (br_imm),
        .i_rs1_data   (rs1_data),
        .i_rs2_data   (rs2_data),
        .o_cmp_rs1    (cmp_rs1),
        .o_cmp_rs2    (cmp_rs2),
        .o_br_un      (br_un),
        .i_br_less    (br_less),
        .i_br_equal   (br_equal),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_taken      (taken),
        .o_target     (target),
        .o_illegal    (illegal),
        .o_misalign   (misalign),
        .o_flush      (flush),
        .i_kill       (kill),
        .i_cnt_clr    (cnt_clr),
        .o_br_cnt     (br_cnt),
        .o_taken_cnt  (taken_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] a, input logic [31:0] b,
                          input int stall, input bit do_kill, input bit do_clr);
        logic [31:0] e_tgt;
        bit e_ill, e_tk, e_mis, e_sgn;
        e_tgt = pc + imm;
        e_ill = (f3 == 3'd2) || (f3 == 3'd3);
        e_tk  = !e_ill && ref_taken(f3, a, b);
        e_mis = e_tk && (e_tgt[1:0] != 2'b00);
        e_sgn = (f3 == 3'd4) || (f3 == 3'd5);

        chk("ready_idle", 32'(br_ready), 32'd1);
        br_valid = 1'b1; br_funct3 = f3; br_pc = pc; br_imm = imm; rs1_data = a; rs2_data = b;
        @(posedge clk); #1;
        br_valid = 1'b0; br_pc = $urandom; br_imm = $urandom; rs1_data = $urandom; rs2_data = $urandom;
        br_funct3 = 3'($urandom);
        #1;
        chk("cmp_valid", 32'(resp_valid), 32'd0);
        chk("cmp_br_un", 32'(br_un), 32'(e_sgn));
        chk("cmp_rs1", cmp_rs1, a);
        chk("cmp_rs2", cmp_rs2, b);
        chk("cmp_ready", 32'(br_ready), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < stall; i++) begin
            chk("stall_valid", 32'(resp_valid), 32'd1);
            chk("stall_taken", 32'(taken), 32'(e_tk));
            chk("stall_target", target, e_tgt);
            chk("stall_ready", 32'(br_ready), 32'd0);
            chk("stall_flush", 32'(flush), 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1; kill = do_kill; cnt_clr = do_clr;
        #1;
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_taken", 32'(taken), 32'(e_tk));
        chk("resp_target", target, e_tgt);
        chk("resp_illegal", 32'(illegal), 32'(e_ill));
        chk("resp_misalign", 32'(misalign), 32'(e_mis));
        chk("resp_ready", 32'(br_ready), 32'd0);
        chk("resp_flush", 32'(flush), 32'(e_tk && !do_kill));
        @(posedge clk); #1;
        resp_ready = 1'b0; kill = 1'b0; cnt_clr = 1'b0;
        if (do_clr) begin
            m_br = 0; m_tk = 0;
        end else if (!do_kill && !e_ill) begin
            if (m_br < CMAX) m_br++;
            if (e_tk && m_tk < CMAX) m_tk++;
        end
        #1;
        chk("post_valid", 32'(resp_valid), 32'd0);
        chk("post_ready", 32'(br_ready), 32'd1);
        chk("post_flush", 32'(flush), 32'd0);
        chk("br_cnt", 32'(br_cnt), 32'(m_br));
        chk("taken_cnt", 32'(taken_cnt), 32'(m_tk));
        $display("br f3=%0d pc=%h imm=%h a=%h b=%h stall=%0d kill=%0d clr=%0d exp_taken=%0d exp_tgt=%h cnt=%0d/%0d",
                 f3, pc, imm, a, b, stall, do_kill, do_clr, e_tk, e_tgt, m_br, m_tk);
    endtask

    initial begin
        rst_n = 1'b0; br_valid = 1'b0; br_funct3 = '0; br_pc = '0; br_imm = '0;
        rs1_data = '0; rs2_data = '0; resp_ready = 1'b0; kill = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(br_ready), 32'd1);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_taken", 32'(taken), 32'd0);
        chk("rst_target", target, 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_br_un", 32'(br_un), 32'd0);
        chk("rst_cmp_rs1", cmp_rs1, 32'd0);
        chk("rst_br_cnt", 32'(br_cnt), 32'd0);
        chk("rst_taken_cnt", 32'(taken_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_br(3'b100, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 0, 0, 0);
        run_br(3'b110, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 0, 0, 0);
        run_br(3'b000, 32'hFFFF_FFF0, 32'h20, 32'h1234, 32'h1234, 0, 0, 0);
        run_br(3'b001, 32'h100, 32'h2, 32'h5, 32'h6, 0, 0, 0);
        run_br(3'b010, 32'h100, 32'h8, 32'h5, 32'h5, 0, 0, 0);
        run_br(3'b101, 32'h200, 32'hFFFF_FFF8, 32'h7, 32'h7, 5, 0, 0);
        run_br(3'b000, 32'h300, 32'h4, 32'h9, 32'h9, 1, 1, 0);

        // Kill in IDLE must block acceptance
        kill = 1'b1; br_valid = 1'b1; br_funct3 = 3'b000;
        #1;
        chk("kill_idle_ready", 32'(br_ready), 32'd0);
        @(posedge clk); #1;
        kill = 1'b0; br_valid = 1'b0;
        #1;
        chk("kill_idle_valid1", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        chk("kill_idle_valid2", 32'(resp_valid), 32'd0);
        chk("kill_idle_ready2", 32'(br_ready), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a, b, imm;
            a   = $urandom;
            b   = ($urandom_range(0, 2) == 0) ? a : 32'($urandom);
            imm = ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC);
            run_br(3'($urandom), $urandom, imm, a, b, $urandom_range(0, 3),
                   $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
        end

        // Saturation, then clear coincident with a handshake
        for (int n = 0; n < CMAX + 3; n++)
            run_br(3'b000, 32'h400, 32'h8, 32'hA5A5, 32'hA5A5, 0, 0, 0);
        chk("sat_br_cnt", 32'(br_cnt), 32'(CMAX));
        chk("sat_taken_cnt", 32'(taken_cnt), 32'(CMAX));
        run_br(3'b000, 32'h400, 32'h8, 32'h1, 32'h1, 0, 0, 1);

        // Asynchronous reset in the middle of a response
        run_br(3'b001, 32'h500, 32'h10, 32'h1, 32'h2, 0, 0, 0);
        br_valid = 1'b1; br_funct3 = 3'b001; br_pc = 32'h600; br_imm = 32'h10;
        rs1_data = 32'h1; rs2_data = 32'h2;
        @(posedge clk); #1;
        br_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_valid", 32'(resp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        m_br = 0; m_tk = 0;
        chk("mid_rst_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_taken", 32'(taken), 32'd0);
        chk("mid_rst_target", target, 32'd0);
        chk("mid_rst_ready", 32'(br_ready), 32'd1);
        chk("mid_rst_br_cnt", 32'(br_cnt), 32'(m_br));
        chk("mid_rst_taken_cnt", 32'(taken_cnt), 32'(m_tk));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_br(3'b111, 32'h700, 32'h40, 32'h10, 32'h3, 2, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
